fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline.
- Owns the program counter and drives the address input of the combinational instruction ROM. It captures the returned word into the IF/ID pipeline register together with PC and PC+4.
- Handles hazard-unit stalls, decode flushes and EX-stage branch/jump redirects.
- Flags fetches outside the ROM window and misaligned redirect targets.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- IMEM_BASE, 32'hBFC00000, first byte address of the instruction ROM window.
- IMEM_BYTES, 4096, size of the ROM window in bytes (power of two).
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall_i  in  1  hold PC and IF/ID (load-use hazard).
- flush_i  in  1  replace the IF/ID contents with a bubble.
- redirect_i  in  1  taken branch/jump resolved in EX.
- redirect_pc_i  in  32  redirect target.
- imem_addr_o  out  32  byte address to the instruction ROM, equals pc_q.
- imem_rd_i  in  32  instruction word returned combinationally for imem_addr_o.
- if_id_instr_o  out  32  captured instruction.
- if_id_pc_o  out  32  PC of the captured instruction.
- if_id_pc4_o  out  32  PC+4 of the captured instruction.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_fault_o  out  1  captured fetch was outside the ROM window.
- misalign_o  out  1  one-cycle pulse when a redirect target has bits[1:0] != 0.
- fetch_count_o  out  32  count of valid instructions written into IF/ID.

Behaviour:
Reset:
- When rst_n=0 at a rising edge: pc_q=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, valid=0, fault=0, misalign=0, fetch_count=0.
- Reset overrides every other input.
- Reset asserted mid-stall or mid-redirect discards all pending state.

Datapath:
- imem_addr_o = pc_q, driven combinationally from the register.
- The instruction at PC appears on the if_id_* outputs one cycle after PC is presented.

Address checks:
- pc_plus4 = pc_q + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- in_window = (pc_q - IMEM_BASE) < IMEM_BYTES, using an unsigned 32-bit compare.

Edge priority (rst_n=1), evaluated in this order:
1. redirect_i=1:
   - pc_q <= {redirect_pc_i[31:2], 2'b00}.
   - IF/ID <= bubble (instr=NOP_INSTR, valid=0, fault=0, pc and pc4 hold).
   - misalign_o <= |redirect_pc_i[1:0].
   - Redirect overrides both stall_i and flush_i.
2. Otherwise stall_i=1:
   - pc_q holds.
   - If flush_i=1, IF/ID <= bubble; else IF/ID holds.
   - misalign_o <= 0.
3. Otherwise flush_i=1:
   - pc_q <= pc_plus4.
   - IF/ID <= bubble.
   - misalign_o <= 0.
4. Otherwise (normal fetch):
   - pc_q <= pc_plus4.
   - if_id_pc <= pc_q; if_id_pc4 <= pc_plus4; valid <= 1; misalign_o <= 0.
   - If in_window: instr <= imem_rd_i, fault <= 0.
   - If not in_window: instr <= NOP_INSTR, fault <= 1.

Counter:
- fetch_count_o increments by 1 on each edge where case 4 writes valid=1.
- Faulted fetches are counted.
- The counter wraps at 2^32.

Other rules:
- A stalled bubble remains valid=0. A stalled valid instruction is presented unchanged for every stalled cycle.
- No combinational path from stall_i, flush_i or redirect_i to any output.

Decomposition:
- Shared package riscv_pkg:
  - constants RESET_PC, NOP_INSTR, IMEM_BASE, IMEM_BYTES.
  - typedef if_id_t: packed struct {instr, pc, pc4, valid, fault}.
- One natural sub-module, if_id_reg:
  - inputs: clk, rst_n, hold, bubble, load, next.
  - output: if_id_t.
  - Reused for later pipeline registers.
- The PC register, next-PC logic and counter stay in fetch_stage.

Test Plan:
1. Reset, then release with ROM words 0x00500093, 0x00300113 at 0xBFC00000/4:
   - imem_addr_o is 0xBFC00000 then 0xBFC00004.
   - if_id_instr_o=0x00500093 with pc=0xBFC00000, pc4=0xBFC00004, valid=1.
   - fetch_count_o=1.
2. stall_i=1 for 2 cycles after the first fetch:
   - PC holds at 0xBFC00004.
   - IF/ID holds 0x00500093.
   - fetch_count_o stays 1.
   - After release, the next instruction is 0x00300113.
3. redirect_i=1 with redirect_pc_i=0xBFC00040 and stall_i=1 in the same cycle:
   - pc_q=0xBFC00040.
   - IF/ID is a bubble (0x00000013, valid=0).
   - The next cycle captures the word at 0x40.
4. redirect_pc_i=0xBFC00042:
   - pc_q=0xBFC00040.
   - misalign_o=1 for exactly one cycle.
5. redirect_pc_i=0xBFC01000 (outside the window):
   - The next fetch gives instr=0x00000013, fault=1, valid=1, count increments.
6. redirect_pc_i=0xFFFFFFFC, then normal fetch:
   - pc_q wraps to 0x00000000.
   - fault=1 on both fetches.
   - Assert rst_n=0 mid-stream: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline constants and pipeline-register types
package riscv_pkg;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] IMEM_BASE  = 32'hBFC0_0000;
    localparam int unsigned IMEM_BYTES = 4096;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
    } if_id_t;

    // True when addr lies inside [base, base+bytes); the wrap of the subtraction
    // makes addresses below base compare as huge offsets.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] bytes);
        logic [31:0] offset;
        offset = addr - base;
        return offset < bytes;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with bubble insertion and hold
import riscv_pkg::*;

module if_id_reg #(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   bubble,
    input  logic   load,
    input  if_id_t next,
    output if_id_t q
);

    // A bubble keeps pc/pc4 so the stage still reports where the squashed slot sat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q.instr <= BUBBLE_INSTR;
            q.pc    <= '0;
            q.pc4   <= '0;
            q.valid <= 1'b0;
            q.fault <= 1'b0;
        end else if (bubble) begin
            q.instr <= BUBBLE_INSTR;
            q.valid <= 1'b0;
            q.fault <= 1'b0;
        end else if (!hold && load) begin
            q <= next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch: PC, ROM window check, IF/ID capture
import riscv_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter logic [31:0] IMEM_BASE  = riscv_pkg::IMEM_BASE,
    parameter int unsigned IMEM_BYTES = riscv_pkg::IMEM_BYTES,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rd_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        if_id_fault_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] WINDOW_BYTES = 32'(IMEM_BYTES);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        in_window;
    logic        load;
    logic        bubble;
    logic        misalign_q;
    logic [31:0] count_q;
    if_id_t      fetch_next;
    if_id_t      if_id_q;

    assign pc_plus4  = pc_q + 32'd4;
    assign in_window = addr_in_window(pc_q, IMEM_BASE, WINDOW_BYTES);

    // Redirect wins over everything; a stall only freezes the PC when no redirect is pending.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end
    end

    assign bubble = redirect_i | flush_i;
    assign load   = !redirect_i && !stall_i && !flush_i;

    always_comb begin
        fetch_next.instr = in_window ? imem_rd_i : NOP_INSTR;
        fetch_next.pc    = pc_q;
        fetch_next.pc4   = pc_plus4;
        fetch_next.valid = 1'b1;
        fetch_next.fault = !in_window;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (load) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (stall_i),
        .bubble (bubble),
        .load   (load),
        .next   (fetch_next),
        .q      (if_id_q)
    );

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_valid_o = if_id_q.valid;
    assign if_id_fault_o = if_id_q.fault;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rd_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic        if_id_fault_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_i     (imem_rd_i),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o),
        .if_id_fault_o (if_id_fault_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'hBFC0_0000;
        if (off >= 32'd4096) return 32'hFFFF_FFFF;
        case (off)
            32'h000: return 32'h0050_0093;
            32'h004: return 32'h0030_0113;
            32'h040: return 32'h00A0_0193;
            32'h044: return 32'h0010_0213;
            32'hFFC: return 32'h0000_006F;
            default: return {20'h12345, off[11:0]};
        endcase
    endfunction

    always_comb imem_rd_i = rom(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%08h required=%08h (check %0d)", name, act, req, popped);
        end
    endtask

    // Monitor: every cycle whose expectation is queued gets all outputs compared.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                popped++;
                chk("imem_addr", imem_addr_o, e.addr);
                chk("instr", if_id_instr_o, e.instr);
                chk("pc", if_id_pc_o, e.pc);
                chk("pc4", if_id_pc4_o, e.pc4);
                chk("valid", 32'(if_id_valid_o), 32'(e.valid));
                chk("fault", 32'(if_id_fault_o), 32'(e.fault));
                chk("misalign", 32'(misalign_o), 32'(e.mis));
                chk("count", fetch_count_o, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs, then queue what the outputs must be after that edge.
    task automatic cyc(input logic rn, input logic st, input logic fl, input logic rd,
                       input logic [31:0] rpc,
                       input logic [31:0] addr, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] pc4,
                       input logic v, input logic f, input logic m, input logic [31:0] cnt);
        exp_t e;
        @(negedge clk);
        rst_n = rn; stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
        @(posedge clk);
        #1;
        e.addr = addr; e.instr = instr; e.pc = pc; e.pc4 = pc4;
        e.valid = v; e.fault = f; e.mis = m; e.cnt = cnt;
        exp_q.push_back(e);
        pushed++;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        //  rn st fl rd rpc            addr          instr         pc            pc4           v f m cnt
        cyc(0, 0, 0, 0, 32'h0,        32'hBFC00000, NOP,          32'h0,        32'h0,        0,0,0,0);
        cyc(0, 0, 0, 0, 32'h0,        32'hBFC00000, NOP,          32'h0,        32'h0,        0,0,0,0);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00004, 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1,0,0,1);
        cyc(1, 1, 0, 0, 32'h0,        32'hBFC00004, 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1,0,0,1);
        cyc(1, 1, 0, 0, 32'h0,        32'hBFC00004, 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1,0,0,1);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00008, 32'h00300113, 32'hBFC00004, 32'hBFC00008, 1,0,0,2);
        cyc(1, 1, 0, 1, 32'hBFC00040, 32'hBFC00040, NOP,          32'hBFC00004, 32'hBFC00008, 0,0,0,2);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00044, 32'h00A00193, 32'hBFC00040, 32'hBFC00044, 1,0,0,3);
        cyc(1, 0, 1, 0, 32'h0,        32'hBFC00048, NOP,          32'hBFC00040, 32'hBFC00044, 0,0,0,3);
        cyc(1, 1, 0, 0, 32'h0,        32'hBFC00048, NOP,          32'hBFC00040, 32'hBFC00044, 0,0,0,3);
        cyc(1, 0, 0, 1, 32'hBFC00042, 32'hBFC00040, NOP,          32'hBFC00040, 32'hBFC00044, 0,0,1,3);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00044, 32'h00A00193, 32'hBFC00040, 32'hBFC00044, 1,0,0,4);
        cyc(1, 0, 0, 1, 32'hBFC01000, 32'hBFC01000, NOP,          32'hBFC00040, 32'hBFC00044, 0,0,0,4);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC01004, NOP,          32'hBFC01000, 32'hBFC01004, 1,1,0,5);
        cyc(1, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,          32'hBFC01000, 32'hBFC01004, 0,0,0,5);
        cyc(1, 0, 0, 0, 32'h0,        32'h00000000, NOP,          32'hFFFFFFFC, 32'h00000000, 1,1,0,6);
        cyc(1, 0, 0, 0, 32'h0,        32'h00000004, NOP,          32'h00000000, 32'h00000004, 1,1,0,7);
        cyc(1, 1, 1, 0, 32'h0,        32'h00000004, NOP,          32'h00000000, 32'h00000004, 0,0,0,7);
        cyc(0, 1, 0, 1, 32'hBFC00042, 32'hBFC00000, NOP,          32'h0,        32'h0,        0,0,0,0);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00004, 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1,0,0,1);
        cyc(1, 0, 0, 1, 32'hBFC00FFF, 32'hBFC00FFC, NOP,          32'hBFC00000, 32'hBFC00004, 0,0,1,1);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC01000, 32'h0000006F, 32'hBFC00FFC, 32'hBFC01000, 1,0,0,2);
        cyc(1, 0, 0, 1, 32'hBFBFFFFC, 32'hBFBFFFFC, NOP,          32'hBFC00FFC, 32'hBFC01000, 0,0,0,2);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00000, NOP,          32'hBFBFFFFC, 32'hBFC00000, 1,1,0,3);
        cyc(1, 0, 0, 0, 32'h0,        32'hBFC00004, 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1,0,0,4);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL drain: actual=%0d compared required=%0d queued", popped, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
